if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the PC and drives the ROM chip-enable and byte address.
- Captures the ROM's combinational instruction word into a small in-order fetch queue.
- Presents {pc, inst} pairs to the IF/ID boundary with a valid/ready handshake, and accepts branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; fetch restarts from here.
- DEPTH, 2, fetch-queue entries; legal values 2 or 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_ce_o  output  1  ROM chip enable; ROM returns zero word when low.
- rom_addr_o  output  32  ROM byte address, always word-aligned.
- rom_inst_i  input  32  ROM instruction, valid in the same cycle as addr when ce=1.
- id_valid_o  output  1  queue head is valid.
- id_pc_o  output  32  PC of queue head; zero when empty.
- id_inst_o  output  32  instruction of queue head; zero when empty.
- id_ready_i  input  1  decode accepts head this cycle.
- redirect_i  input  1  flush and restart fetch.
- redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored (forced to 0).

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, queue count=0, state=BOOT.
  - rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- States:
  - BOOT: one cycle after rst deasserts; ce=0, no push. Next state FETCH.
  - FETCH: normal operation.
  - REDIR: one bubble cycle after a redirect; ce=0. Next state FETCH.
  - redirect_i=1 in any state → next state REDIR.
- Pop and push:
  - pop = id_valid_o & id_ready_i.
  - rom_ce_o = (state==FETCH) & ~redirect_i & (count<DEPTH | pop).
  - rom_addr_o = pc at all times.
  - When rom_ce_o=1 at a clock edge: push {pc, rom_inst_i} to queue tail, then pc <= pc+4.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Fetch latency: an instruction is visible on id_* one cycle after its address was driven. First id_valid_o occurs on the 2nd edge after reset release (BOOT, then fetch).
- Full queue: push and pop in the same cycle are allowed; count is unchanged and order is preserved. Queue full with no pop → ce=0, pc holds.
- Empty queue: id_valid_o=0 and id_* are zero. id_ready_i is ignored.
- Redirect:
  - redirect_i=1 at an edge: queue cleared (count=0), pc <= {redirect_pc_i[31:2],2'b00}.
  - Any same-cycle pop or push is discarded.
  - First redirected instruction is valid on id_* 2 edges later.
  - Back-to-back redirects: the last one wins; REDIR is re-entered each time.
- Order: strictly FIFO; id_* are driven from registered queue storage with no combinational path from rom_inst_i.
- Reset mid-operation: all state cleared immediately, with no output glitch beyond the async clear.
- Widths: all PC/instruction buses are 32 bits, using the shared address/instruction width macros.

Decomposition:
- Shared defines header gains:
  - InstAddrBus/InstBus width macros (already shared).
  - RESET_PC default macro.
  - FSM state encodings IF_BOOT/IF_FETCH/IF_REDIR (2 bits).
- One sub-module, fetch_fifo:
  - Parameterised DEPTH×64-bit synchronous FIFO with async clear, sync flush, and simultaneous push/pop.
  - Exposes count, full, empty.
- if_fetch keeps the FSM, PC and ce logic.

Test Plan:
1. Reset then id_ready_i=1 constantly, ROM word = addr → id_pc/id_inst sequence 0,4,8,12 on consecutive cycles from the 2nd post-reset edge; rom_ce_o=0 during BOOT.
2. id_ready_i=0 for 5 cycles → queue fills with 2 entries (pc 0,4); rom_ce_o=0 with rom_addr_o held at 8. Raise ready → 0,4,8 delivered in order with no loss or duplicate.
3. Redirect to 32'h0000_0102 while queue is full and ready=1 → queue emptied next cycle, rom_addr_o=32'h0000_0100, one ce=0 bubble, first delivered pc=0x100.
4. RESET_PC=32'hFFFF_FFF8 → delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
5. Assert rst while the queue holds 2 entries → id_valid_o=0 and rom_addr_o=RESET_PC immediately, before any clock edge. Restart matches scenario 1.
6. Redirects on two consecutive cycles (to 0x40 then 0x80) → only 0x80 stream appears; no instruction from 0x40 is delivered.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, reset default and fetch-stage state encoding.
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned FetchEntryW = InstAddrBus + InstBus;

    localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_FETCH = 2'd1,
        IF_REDIR = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// In-order fetch queue: DEPTH entries, async clear, sync flush, push and pop in the same cycle.
module if_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign count = count_q;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush & ~empty;

    // Head is read straight from storage; zero when nothing is queued.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; needs no reset because empty masks the read port.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the ROM and queues {pc, inst} for decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned            DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_inst_i,
    output logic                   id_valid_o,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o,
    input  logic                   id_ready_i,
    input  logic                   redirect_i,
    input  logic [InstAddrBus-1:0] redirect_pc_i
);

    localparam int unsigned CntW = $clog2(DEPTH+1);

    if_state_e              state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   pop;
    logic [FetchEntryW-1:0] head;
    logic [CntW-1:0]        fifo_count;
    logic                   fifo_full, fifo_empty;

    assign pop        = id_valid_o & id_ready_i;
    assign id_valid_o = ~fifo_empty;
    assign rom_addr_o = pc_q;
    assign id_pc_o    = head[FetchEntryW-1:InstBus];
    assign id_inst_o  = head[InstBus-1:0];

    if_fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(FetchEntryW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect_i),
        .push (rom_ce_o),
        .pop  (pop),
        .wdata({pc_q, rom_inst_i}),
        .rdata(head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Next state, next PC and ROM enable; a redirect overrides everything else.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rom_ce_o = (state_q == IF_FETCH) & ~redirect_i & (~fifo_full | pop);

        case (state_q)
            IF_BOOT:  state_d = IF_FETCH;
            IF_REDIR: state_d = IF_FETCH;
            IF_FETCH: state_d = IF_FETCH;
            default:  state_d = IF_BOOT;
        endcase

        if (rom_ce_o) pc_d = pc_q + 32'd4;

        if (redirect_i) begin
            state_d = IF_REDIR;
            pc_d    = redirect_pc_i & ~32'h3;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Occupancy and full flag must never disagree.
    assert property (@(posedge clk) disable iff (rst) fifo_full == (fifo_count == CntW'(DEPTH)));

endmodule
